// File: rtl/ahb_sram_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
// Address-phase signals flow master to slave; ready/response/read data flow back.
interface ahb_sram_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// Word-organised AHB-Lite SRAM slave with configurable OKAY wait states
// and a two-cycle ERROR response for out-of-range or misaligned accesses.
module ahb_sram_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic      clk,
    input  logic      reset,
    ahb_sram_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH);
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_hreadyout;
    logic           r_hresp;
    logic           r_dp_valid;
    logic           r_dp_write;
    logic [3:0]     r_be;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_mem [DEPTH];

    logic           w_accept;
    logic           w_legal;
    logic           w_commit;
    logic           w_unused;

    function automatic logic is_legal(input logic [31:0] addr, input logic [2:0] size);
        is_legal = (addr[31:2] < DEPTH_LIM) &&
                   (size <= 3'd2) &&
                   !((size == 3'd1) && addr[0]) &&
                   !((size == 3'd2) && (addr[1:0] != 2'b00));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lo, input logic [2:0] size);
        case (size)
            3'd0:    lane_mask = 4'b0001 << lo;
            3'd1:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Only states that present HREADYOUT=1 can take a new address phase.
    assign w_accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY & r_hreadyout;
    assign w_legal  = is_legal(bus.HADDR, bus.HSIZE);
    assign w_commit = r_dp_valid & r_dp_write & r_hreadyout;
    assign w_unused = bus.HTRANS[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_dp_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= S_DONE;
                        r_hreadyout <= 1'b1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    // IDLE, DONE and ERR2 share the address-phase decision.
                    if (w_accept && !w_legal) begin
                        r_state     <= S_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                        r_dp_valid  <= 1'b0;
                    end else if (w_accept && (WAIT_STATES == 0)) begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                        r_dp_valid  <= 1'b1;
                    end else if (w_accept) begin
                        r_state     <= S_WAIT;
                        r_cnt       <= WS_LOAD;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b0;
                        r_dp_valid  <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                        r_dp_valid  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx      <= bus.HADDR[AW+1:2];
            r_be       <= lane_mask(bus.HADDR[1:0], bus.HSIZE);
            r_dp_write <= bus.HWRITE;
        end
    end

    // A reset arriving on the commit edge drops the pending write.
    always_ff @(posedge clk) begin
        if (reset && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = (r_dp_valid && !r_dp_write) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one zero-wait and one three-wait instance share a
// master; results are compared against a byte-lane memory model.
module tb_ahb_sram_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic        m_sel_ws3;
    logic        m_hsel;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic        o_rdy;
    logic        o_resp;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model0 [256];
    logic [31:0] model3 [256];

    always #5 clk = ~clk;

    ahb_sram_if if0 ();
    ahb_sram_if if3 ();

    assign if0.HSEL   = m_hsel & ~m_sel_ws3;
    assign if3.HSEL   = m_hsel & m_sel_ws3;
    assign if0.HADDR  = m_haddr;
    assign if3.HADDR  = m_haddr;
    assign if0.HTRANS = m_htrans;
    assign if3.HTRANS = m_htrans;
    assign if0.HWRITE = m_hwrite;
    assign if3.HWRITE = m_hwrite;
    assign if0.HSIZE  = m_hsize;
    assign if3.HSIZE  = m_hsize;
    assign if0.HWDATA = m_hwdata;
    assign if3.HWDATA = m_hwdata;
    assign if0.HREADY = if0.HREADYOUT;
    assign if3.HREADY = if3.HREADYOUT;

    assign o_rdy   = m_sel_ws3 ? if3.HREADYOUT : if0.HREADYOUT;
    assign o_resp  = m_sel_ws3 ? if3.HRESP     : if0.HRESP;
    assign o_rdata = m_sel_ws3 ? if3.HRDATA    : if0.HRDATA;

    ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    // Single non-pipelined transfer; waits=99 flags an expired cycle budget.
    task automatic xfer(input logic ws3, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output int waits, output logic resp_first,
                        output logic resp_last, output logic [31:0] rdata);
        logic done;
        m_sel_ws3 = ws3;
        @(posedge clk); #1;
        m_hsel = 1'b1; m_htrans = 2'd2; m_haddr = addr; m_hwrite = wr; m_hsize = size;
        @(posedge clk); #1;
        m_hsel = 1'b0; m_htrans = 2'd0; m_hwdata = wdata;
        waits = 0; resp_first = 1'b0; resp_last = 1'b0; rdata = 32'h0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) resp_first = o_resp;
            if (o_rdy) begin
                resp_last = o_resp;
                rdata     = o_rdata;
                done      = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!done) waits = 99;
    endtask

    task automatic model_write(input logic ws3, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] data);
        int idx;
        int lane;
        logic [31:0] w;
        idx = int'(addr >> 2);
        w = ws3 ? model3[idx] : model0[idx];
        for (int k = 0; k < (1 << size); k++) begin
            lane = int'(addr % 4) + k;
            w[lane*8 +: 8] = data[lane*8 +: 8];
        end
        if (ws3) model3[idx] = w; else model0[idx] = w;
    endtask

    function automatic logic legal(input logic [31:0] addr, input logic [2:0] size);
        if ((addr / 4) >= 256) return 1'b0;
        if (size > 2) return 1'b0;
        if (addr % (32'd1 << size) != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        m_sel_ws3 = 1'b0; m_hsel = 1'b0; m_htrans = 2'd0; m_haddr = 32'h0;
        m_hwrite = 1'b0; m_hsize = 3'd2; m_hwdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (if0.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_rdy0 got %b want 1", if0.HREADYOUT); end
        if (if0.HRESP !== 1'b0) begin errors++; $display("FAIL reset_resp0 got %b want 0", if0.HRESP); end
        if (if0.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got %h want 0", if0.HRDATA); end
        if (if3.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_rdy3 got %b want 1", if3.HREADYOUT); end
        if (if3.HRESP !== 1'b0) begin errors++; $display("FAIL reset_resp3 got %b want 0", if3.HRESP); end
        if (if3.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got %h want 0", if3.HRDATA); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_word_rw();
        int w; logic rf, rl; logic [31:0] rd;
        xfer(1'b0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, w, rf, rl, rd);
        checks += 2;
        if (w !== 0) begin errors++; $display("FAIL word_wr_waits got %0d want 0", w); end
        if (rl !== 1'b0) begin errors++; $display("FAIL word_wr_resp got %b want 0", rl); end
        xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks += 3;
        if (w !== 0) begin errors++; $display("FAIL word_rd_waits got %0d want 0", w); end
        if (rl !== 1'b0) begin errors++; $display("FAIL word_rd_resp got %b want 0", rl); end
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd_data got %h want deadbeef", rd); end
    endtask

    task automatic test_subword();
        int w; logic rf, rl; logic [31:0] rd;
        xfer(1'b0, 32'h10, 1'b1, 3'd2, 32'h11223344, w, rf, rl, rd);
        xfer(1'b0, 32'h11, 1'b1, 3'd0, 32'hAAAAAAAA, w, rf, rl, rd);
        xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks++;
        if (rd !== 32'h1122AA44) begin errors++; $display("FAIL byte_lane got %h want 1122aa44", rd); end
        xfer(1'b0, 32'h12, 1'b1, 3'd1, 32'h55665566, w, rf, rl, rd);
        xfer(1'b0, 32'h13, 1'b0, 3'd0, 32'h0, w, rf, rl, rd);
        checks++;
        if (rd !== 32'h5566AA44) begin errors++; $display("FAIL half_lane got %h want 5566aa44", rd); end
    endtask

    task automatic test_wait_states();
        int w; logic rf, rl; logic [31:0] rd;
        xfer(1'b1, 32'h40, 1'b1, 3'd2, 32'hCAFEF00D, w, rf, rl, rd);
        checks++;
        if (w !== 3) begin errors++; $display("FAIL ws_wr_waits got %0d want 3", w); end
        xfer(1'b1, 32'h40, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks += 3;
        if (w !== 3) begin errors++; $display("FAIL ws_rd_waits got %0d want 3", w); end
        if (rl !== 1'b0) begin errors++; $display("FAIL ws_rd_resp got %b want 0", rl); end
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_rd_data got %h want cafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        int lows; int w; logic rf, rl; logic [31:0] rd;
        m_sel_ws3 = 1'b1;
        @(posedge clk); #1;
        m_hsel = 1'b1; m_htrans = 2'd2; m_haddr = 32'h0; m_hwrite = 1'b1; m_hsize = 3'd2;
        @(posedge clk); #1;
        m_hwdata = 32'hA5A50000; m_haddr = 32'h4;
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_rdy) break;
            lows++;
        end
        checks++;
        if (lows !== 3) begin errors++; $display("FAIL b2b_first_waits got %0d want 3", lows); end
        @(posedge clk); #1;
        m_hsel = 1'b0; m_htrans = 2'd0; m_hwdata = 32'h0000A5A5;
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_rdy) break;
            lows++;
        end
        checks++;
        if (lows !== 3) begin errors++; $display("FAIL b2b_second_waits got %0d want 3", lows); end
        xfer(1'b1, 32'h0, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks++;
        if (rd !== 32'hA5A50000) begin errors++; $display("FAIL b2b_rd0 got %h want a5a50000", rd); end
        xfer(1'b1, 32'h4, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks++;
        if (rd !== 32'h0000A5A5) begin errors++; $display("FAIL b2b_rd4 got %h want 0000a5a5", rd); end
    endtask

    task automatic test_error();
        int w; logic rf, rl; logic [31:0] rd;
        xfer(1'b0, 32'h400, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks += 4;
        if (w !== 1) begin errors++; $display("FAIL err_oor_waits got %0d want 1", w); end
        if (rf !== 1'b1) begin errors++; $display("FAIL err_oor_err1_resp got %b want 1", rf); end
        if (rl !== 1'b1) begin errors++; $display("FAIL err_oor_err2_resp got %b want 1", rl); end
        if (rd !== 32'h0) begin errors++; $display("FAIL err_oor_rdata got %h want 0", rd); end
        @(negedge clk);
        checks += 2;
        if (o_rdy !== 1'b1) begin errors++; $display("FAIL err_idle_rdy got %b want 1", o_rdy); end
        if (o_resp !== 1'b0) begin errors++; $display("FAIL err_idle_resp got %b want 0", o_resp); end
        xfer(1'b0, 32'h0, 1'b1, 3'd2, 32'h13572468, w, rf, rl, rd);
        xfer(1'b0, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, w, rf, rl, rd);
        checks += 2;
        if (w !== 1) begin errors++; $display("FAIL err_mis_waits got %0d want 1", w); end
        if (rl !== 1'b1) begin errors++; $display("FAIL err_mis_resp got %b want 1", rl); end
        xfer(1'b0, 32'h0, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks++;
        if (rd !== 32'h13572468) begin errors++; $display("FAIL err_mis_mem got %h want 13572468", rd); end
        xfer(1'b1, 32'h404, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks += 2;
        if (w !== 1) begin errors++; $display("FAIL err_ws3_waits got %0d want 1", w); end
        if (rl !== 1'b1) begin errors++; $display("FAIL err_ws3_resp got %b want 1", rl); end
    endtask

    task automatic test_burst_busy();
        int w; logic rf, rl; logic [31:0] rd;
        logic [31:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = $urandom;
        m_sel_ws3 = 1'b0;
        @(posedge clk); #1;
        m_hsel = 1'b1; m_htrans = 2'd2; m_haddr = 32'h20; m_hwrite = 1'b1; m_hsize = 3'd2;
        @(posedge clk); #1;
        m_hwdata = d[0]; m_htrans = 2'd3; m_haddr = 32'h24;
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b1 || o_resp !== 1'b0) begin errors++; $display("FAIL burst_beat0 got rdy=%b resp=%b want 1 0", o_rdy, o_resp); end
        @(posedge clk); #1;
        m_hwdata = d[1]; m_htrans = 2'd1; m_haddr = 32'h28;
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b1 || o_resp !== 1'b0) begin errors++; $display("FAIL burst_beat1 got rdy=%b resp=%b want 1 0", o_rdy, o_resp); end
        @(posedge clk); #1;
        m_hwdata = 32'hBAD0BAD0; m_htrans = 2'd3; m_haddr = 32'h28;
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b1 || o_resp !== 1'b0) begin errors++; $display("FAIL burst_busy got rdy=%b resp=%b want 1 0", o_rdy, o_resp); end
        @(posedge clk); #1;
        m_hsel = 1'b0; m_htrans = 2'd0; m_hwdata = d[2];
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b1 || o_resp !== 1'b0) begin errors++; $display("FAIL burst_beat2 got rdy=%b resp=%b want 1 0", o_rdy, o_resp); end
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 32'h20 + 32'(4*i), 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
            checks++;
            if (rd !== d[i]) begin errors++; $display("FAIL burst_rd%0d got %h want %h", i, rd, d[i]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int w; logic rf, rl; logic [31:0] rd;
        xfer(1'b1, 32'h30, 1'b1, 3'd2, 32'h01234567, w, rf, rl, rd);
        @(posedge clk); #1;
        m_hsel = 1'b1; m_htrans = 2'd2; m_haddr = 32'h30; m_hwrite = 1'b1; m_hsize = 3'd2;
        @(posedge clk); #1;
        m_hsel = 1'b0; m_htrans = 2'd0; m_hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_wait got rdy=%b want 0", o_rdy); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (o_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got %b want 1", o_rdy); end
        if (o_resp !== 1'b0) begin errors++; $display("FAIL rstmid_resp got %b want 0", o_resp); end
        if (o_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h want 0", o_rdata); end
        @(posedge clk); #1;
        reset = 1'b1;
        xfer(1'b1, 32'h30, 1'b0, 3'd2, 32'h0, w, rf, rl, rd);
        checks += 2;
        if (w !== 3) begin errors++; $display("FAIL rstmid_rd_waits got %0d want 3", w); end
        if (rd !== 32'h01234567) begin errors++; $display("FAIL rstmid_keep got %h want 01234567", rd); end
    endtask

    task automatic test_random(input logic ws3);
        int w; logic rf, rl; logic [31:0] rd;
        logic [31:0] addr, data, exp_rd;
        logic [2:0] size;
        logic wr, ok;
        int kind, exp_w;
        for (int i = 64; i < 80; i++) begin
            data = $urandom;
            xfer(ws3, 32'(4*i), 1'b1, 3'd2, data, w, rf, rl, rd);
            model_write(ws3, 32'(4*i), 3'd2, data);
        end
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7)       addr = 32'h100 + $urandom_range(0, 63);
            else if (kind == 7) addr = 32'h400 + $urandom_range(0, 255);
            else if (kind == 8) addr = $urandom | 32'h8000_0000;
            else                addr = 32'h0001_0100 + $urandom_range(0, 63);
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            wr   = 1'($urandom_range(0, 1));
            data = $urandom;
            ok   = legal(addr, size);
            exp_w = ok ? (ws3 ? 3 : 0) : 1;
            exp_rd = 32'h0;
            if (ok && !wr) exp_rd = ws3 ? model3[int'(addr >> 2)] : model0[int'(addr >> 2)];
            xfer(ws3, addr, wr, size, data, w, rf, rl, rd);
            if (ok && wr) model_write(ws3, addr, size, data);
            checks += 3;
            if (w !== exp_w) begin errors++; $display("FAIL rand_waits ws3=%b addr=%h size=%0d got %0d want %0d", ws3, addr, size, w, exp_w); end
            if (rl !== !ok) begin errors++; $display("FAIL rand_resp ws3=%b addr=%h size=%0d got %b want %b", ws3, addr, size, rl, !ok); end
            if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata ws3=%b addr=%h got %h want %h", ws3, addr, rd, exp_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_subword();
        test_wait_states();
        test_back_to_back();
        test_error();
        test_burst_busy();
        test_reset_mid_wait();
        test_random(1'b0);
        test_random(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave memory that sits directly downstream of the bench's `ahb_intf` and the DUT wrapper. It provides a word-organised SRAM that the bus master reads and writes. The block responds with configurable wait states and a two-cycle ERROR response for illegal accesses. It is the first real target the bench drives, so that master-side sequences are checked against known read-back behaviour.

## Interface
- `DEPTH`, 256: number of 32-bit words; must be a power of two, at least 4.
- `WAIT_STATES`, 0: wait cycles inserted in every OKAY data phase (0–15).
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on rising `clk`.
- `HSEL` input 1: slave select.
- `HADDR` input 32: byte address.
- `HTRANS` input 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HWRITE` input 1: 1 = write.
- `HSIZE` input 3: 0 = byte, 1 = halfword, 2 = word.
- `HWDATA` input 32: write data, valid in the data phase.
- `HREADY` input 1: bus-level ready; an address phase is accepted only when this is high.
- `HREADYOUT` output 1: slave ready.
- `HRESP` output 1: 0 = OKAY, 1 = ERROR.
- `HRDATA` output 32: read data.

## Operation
- Accept condition: `HSEL & HTRANS[1] & HREADY` on a rising edge.
  - On accept, latch the address, write flag and size for the data phase.
  - IDLE and BUSY transfers, or `HSEL`=0, are not accepted. They produce a zero-wait OKAY (`HREADYOUT`=1, `HRESP`=0).
- Legality check, performed on the accepted address phase. The transfer is illegal if any of these hold:
  - `HADDR[31:2]` >= `DEPTH`;
  - `HSIZE` > 2;
  - `HSIZE`=1 with `HADDR[0]`=1;
  - `HSIZE`=2 with `HADDR[1:0]`≠0.
- FSM states:
  - IDLE: `HREADYOUT`=1, `HRESP`=0.
    - Legal accept with `WAIT_STATES`=0 → stay in IDLE; the data phase completes next cycle.
    - Legal accept with `WAIT_STATES`>0 → WAIT, with the counter loaded to `WAIT_STATES`.
    - Illegal accept → ERR1.
  - WAIT: `HREADYOUT`=0, `HRESP`=0. The counter decrements each cycle; when it reaches 1 → DONE.
  - DONE: `HREADYOUT`=1, `HRESP`=0. This cycle completes the data phase.
    - A new accept in this cycle follows the IDLE rules.
    - Otherwise → IDLE.
  - ERR1: `HREADYOUT`=0, `HRESP`=1 → ERR2.
  - ERR2: `HREADYOUT`=1, `HRESP`=1.
    - An accept in this cycle follows the IDLE rules.
    - Otherwise → IDLE.
- Write commit:
  - Occurs on the rising edge that ends a legal write data phase (`HREADYOUT`=1), using `HWDATA` of that cycle.
  - Lanes are little-endian. Byte: lane `HADDR[1:0]`. Halfword: lanes `{HADDR[1],0}` and `{HADDR[1],1}`. Word: all four lanes. Untouched lanes keep their value.
- Read data:
  - `HRDATA` is the full 32-bit word at the latched index, combinational from the array, during a legal read data phase.
  - Otherwise `HRDATA`=0.
  - Sub-word reads return the whole word; the master selects the lanes.
- Errored transfers never modify memory.
- Memory contents are not reset.

## Timing
- Reset values: `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, FSM=IDLE, wait counter=0.
- Reset asserted mid-transfer: the pending data phase is dropped and no write is committed. Outputs take their reset values on the next edge.
- OKAY latency: the data phase lasts `WAIT_STATES`+1 cycles after the address phase.
- ERROR latency: always exactly 2 cycles (ERR1, ERR2), independent of `WAIT_STATES`.
- Pipelining: a new address phase is accepted in the same cycle a data phase completes. Back-to-back transfers with `WAIT_STATES`=0 sustain one transfer per cycle.
- Stalled address phases: while `HREADY`=0, address-phase inputs are ignored and the master holds them.
- Read-after-write to the same word in the next transfer returns the newly written data. The commit edge precedes the read data phase.
- Address wrap: only `HADDR[log2(DEPTH)+1:2]` indexes the array. Out-of-range addresses are errors and never alias.

## Test plan
- Reset, then word write 0xDEADBEEF at 0x10, then word read 0x10 (`WAIT_STATES`=0) → `HRDATA`=0xDEADBEEF in the read data phase, `HRESP`=0, no `HREADYOUT` low cycles.
- Byte write 0xAA at 0x11 over word 0x11223344 at 0x10 → read of 0x10 returns 0x1122AA44. Halfword write 0x5566 at 0x12 → 0x5566AA44.
- `WAIT_STATES`=3, read → `HREADYOUT` low exactly 3 cycles, then high with valid data. Back-to-back writes at 0x0 and 0x4 both commit.
- Word read at 0x400 with `DEPTH`=256 → ERR1 (`HREADYOUT`=0, `HRESP`=1), then ERR2 (`HREADYOUT`=1, `HRESP`=1), then IDLE. Misaligned word write at 0x2 → same two-cycle ERROR and memory unchanged.
- Burst NONSEQ, SEQ, SEQ writes to 0x20, 0x24, 0x28 with `WAIT_STATES`=0, with a BUSY cycle inserted → BUSY gets OKAY and no write. Read-back returns all three values.
- `reset` driven low during a WAIT-state write → outputs at reset values next cycle, and the target word retains its old value.
